// File: rtl/tx_len_pattern_gen.sv
// tx_len_pattern_gen
//   Reads a little-endian length header plus a mode byte from an 8-bit stream.
//   Then emits that many bytes of a test pattern on a BW-byte AXI-stream,
//   where BW = 2^OUT_EW.
//   Patterns: byte counter (mode 0/3), zero fill (mode 1), or 0x11D Galois LFSR (mode 2).
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   i_tready/i_tvalid/i_tdata  8-bit header input; ready only while idle (S_HDR)
//   o_tready/o_tvalid          output handshake
//   o_tdata                    output beat, lane 0 = earliest byte
//   o_tkeep                    per-lane byte enable; unused lanes carry 0
//   o_tlast                    final beat of a transfer
//   busy                       high while a transfer is being sent
module tx_len_pattern_gen #(
  parameter int OUT_EW    = 2,
  parameter int LEN_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  output logic                           i_tready,
  input  logic                           i_tvalid,
  input  logic [7:0]                     i_tdata,
  input  logic                           o_tready,
  output logic                           o_tvalid,
  output logic [8*(1<<OUT_EW)-1:0]       o_tdata,
  output logic [(1<<OUT_EW)-1:0]         o_tkeep,
  output logic                           o_tlast,
  output logic                           busy
);

  localparam int BW = 1 << OUT_EW;
  localparam int LW = 8 * LEN_BYTES;
  localparam int IW = $clog2(LEN_BYTES + 1);

  typedef enum logic {S_HDR, S_SEND} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     hdr_idx_reg;
  logic [LW-1:0]     len_reg;
  logic [1:0]        mode_reg;
  // rem/cnt/lfsr describe the bytes not yet loaded into the output register
  logic [LW:0]       rem_reg;
  logic [7:0]        cnt_reg;
  logic [7:0]        lfsr_reg;
  logic              o_tvalid_reg;
  logic [8*BW-1:0]   o_tdata_reg;
  logic [BW-1:0]     o_tkeep_reg;
  logic              o_tlast_reg;

  logic hdr_fire, mode_fire, start, beat_fire, advance;

  assign hdr_fire  = i_tvalid & i_tready;
  assign mode_fire = hdr_fire & (hdr_idx_reg == IW'(LEN_BYTES));
  assign start     = mode_fire & (len_reg != '0);
  assign beat_fire = o_tvalid_reg & o_tready;
  assign advance   = beat_fire & ~o_tlast_reg;

  // The beat generator runs either on the freshly parsed header (start) or on the
  // pending state, so the first beat appears one cycle after the mode byte.
  logic [LW:0]     gen_rem;
  logic [7:0]      gen_cnt;
  logic [7:0]      gen_lfsr;
  logic [1:0]      gen_mode;

  assign gen_rem  = start ? {1'b0, len_reg} : rem_reg;
  assign gen_cnt  = start ? 8'h00 : cnt_reg;
  assign gen_lfsr = start ? 8'h01 : lfsr_reg;
  assign gen_mode = start ? i_tdata[1:0] : mode_reg;

  logic              beat_last;
  logic [OUT_EW:0]   beat_n;
  logic [8*BW-1:0]   beat_data;
  logic [BW-1:0]     beat_keep;
  logic [7:0]        beat_lfsr_next;
  logic [7:0]        lfsr_chain [0:BW];
  logic [7:0]        lane_k;

  always_comb begin
    beat_last      = (gen_rem <= (LW+1)'(BW));
    beat_n         = beat_last ? gen_rem[OUT_EW:0] : (OUT_EW+1)'(BW);
    beat_data      = '0;
    beat_keep      = '0;
    lane_k         = 8'h00;
    lfsr_chain[0]  = gen_lfsr;
    for (int j = 0; j < BW; j++) begin
      lfsr_chain[j+1] = {lfsr_chain[j][6:0], 1'b0} ^ (lfsr_chain[j][7] ? 8'h1D : 8'h00);
    end
    // Stored LFSR advances only by the bytes actually emitted in this beat
    beat_lfsr_next = gen_lfsr;
    for (int j = 1; j <= BW; j++) begin
      if (beat_n == (OUT_EW+1)'(j)) beat_lfsr_next = lfsr_chain[j];
    end
    for (int j = 0; j < BW; j++) begin
      lane_k = gen_cnt + 8'(j);
      if ((OUT_EW+1)'(j) < beat_n) begin
        beat_keep[j] = 1'b1;
        case (gen_mode)
          2'd1:    beat_data[8*j +: 8] = 8'h00;
          2'd2:    beat_data[8*j +: 8] = lfsr_chain[j];
          default: beat_data[8*j +: 8] = lane_k;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= S_HDR;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HDR:   if (start) state_next = S_SEND;
      S_SEND:  if (beat_fire && o_tlast_reg) state_next = S_HDR;
      default: state_next = S_HDR;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    i_tready = (state_reg == S_HDR);
    busy     = (state_reg == S_SEND);
  end

  // Header parsing and beat datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr_idx_reg  <= '0;
      len_reg      <= '0;
      mode_reg     <= 2'd0;
      rem_reg      <= '0;
      cnt_reg      <= 8'h00;
      lfsr_reg     <= 8'h01;
      o_tvalid_reg <= 1'b0;
      o_tdata_reg  <= '0;
      o_tkeep_reg  <= '0;
      o_tlast_reg  <= 1'b0;
    end else begin
      if (hdr_fire) begin
        if (mode_fire) begin
          hdr_idx_reg <= '0;
          mode_reg    <= i_tdata[1:0];
        end else begin
          hdr_idx_reg <= hdr_idx_reg + IW'(1);
          for (int i = 0; i < LEN_BYTES; i++) begin
            if (hdr_idx_reg == IW'(i)) len_reg[8*i +: 8] <= i_tdata;
          end
        end
      end
      if (start || advance) begin
        o_tvalid_reg <= 1'b1;
        o_tdata_reg  <= beat_data;
        o_tkeep_reg  <= beat_keep;
        o_tlast_reg  <= beat_last;
        rem_reg      <= gen_rem - (LW+1)'(beat_n);
        cnt_reg      <= gen_cnt + 8'(beat_n);
        lfsr_reg     <= beat_lfsr_next;
      end else if (beat_fire) begin
        o_tvalid_reg <= 1'b0;
        o_tdata_reg  <= '0;
        o_tkeep_reg  <= '0;
        o_tlast_reg  <= 1'b0;
      end
    end
  end

  assign o_tvalid = o_tvalid_reg;
  assign o_tdata  = o_tdata_reg;
  assign o_tkeep  = o_tkeep_reg;
  assign o_tlast  = o_tlast_reg;

endmodule
